// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the cache refill controller.
// Holds the controller FSM state encoding, the default block size, the
// block-offset width and the line-alignment helper used for address latching.
package cache_pkg;

  localparam int          BLOCK_WORDS = 4;
  localparam int          OFFSET_W    = 4;
  localparam logic [31:0] LINE_MASK   = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RF   = 2'd2,
    UPD  = 2'd3
  } state_t;

  // Clear the block-offset bits so the address points at the start of the line.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & LINE_MASK;
  endfunction

endpackage

// File: rtl/cache_stat_ctr.sv
// cache_stat_ctr: CNT_W-bit statistics counter that saturates at all-ones.
module cache_stat_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count increments, holding at the maximum value once reached.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= {CNT_W{1'b0}};
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: blocking miss handler for a write-back cache.
// A miss optionally writes the dirty victim block back to memory, then
// refills the new block one word per acknowledged beat, then pulses update.
// Optional hit/miss statistics are built only when CACHE_STATS_EN is defined;
// otherwise hit_cnt and miss_cnt are tied to zero.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             hit,
  input  logic             miss,
  input  logic             evict_dirty,
  input  logic [31:0]      wb_addr,
  input  logic [31:0]      rf_addr,
  input  logic [31:0]      ow0,
  input  logic [31:0]      ow1,
  input  logic [31:0]      ow2,
  input  logic [31:0]      ow3,
  output logic             stall,
  output logic             writeback,
  output logic             update,
  output logic [31:0]      w0,
  output logic [31:0]      w1,
  output logic [31:0]      w2,
  output logic [31:0]      w3,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  // Beat counter is at least 2 bits so it can always index the 4 word ports.
  localparam int              BEAT_W    = (BLOCK_WORDS > 4) ? $clog2(BLOCK_WORDS) : 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  state_t            state;
  state_t            next_state;
  logic [BEAT_W-1:0] beat;
  logic [31:0]       wb_base;
  logic [31:0]       rf_base;
  logic [31:0]       words [4];
  logic [31:0]       ow_arr [4];
  logic [31:0]       ow_word;
  logic [31:0]       beat_offset;
  logic              accept_miss;
  logic              beat_ack;
  logic              last_beat;
  logic              beat_in_ports;

  assign ow_arr[0]     = ow0;
  assign ow_arr[1]     = ow1;
  assign ow_arr[2]     = ow2;
  assign ow_arr[3]     = ow3;
  assign beat_in_ports = ({{(32-BEAT_W){1'b0}}, beat} < 32'd4);
  assign ow_word       = beat_in_ports ? ow_arr[beat[1:0]] : 32'd0;
  assign beat_offset   = {{(30-BEAT_W){1'b0}}, beat, 2'b00};
  assign accept_miss   = (state == IDLE) && miss;
  assign beat_ack      = mem_req && mem_ack;
  assign last_beat     = (beat == LAST_BEAT);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: bursts advance only on the acknowledged last beat.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (miss) begin
          next_state = evict_dirty ? WB : RF;
        end else begin
          next_state = IDLE;
        end
      end
      WB: begin
        if (beat_ack && last_beat) begin
          next_state = RF;
        end else begin
          next_state = WB;
        end
      end
      RF: begin
        if (beat_ack && last_beat) begin
          next_state = UPD;
        end else begin
          next_state = RF;
        end
      end
      UPD:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: strobes and the memory beat derived from state and beat.
  always_comb begin
    stall     = 1'b1;
    writeback = 1'b0;
    update    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    case (state)
      IDLE: begin
        stall = miss;
      end
      WB: begin
        writeback = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wb_base + beat_offset;
        mem_wdata = ow_word;
      end
      RF: begin
        mem_req  = 1'b1;
        mem_addr = rf_base + beat_offset;
      end
      UPD: begin
        update = 1'b1;
      end
      default: begin
        stall = 1'b1;
      end
    endcase
  end

  // Beat counter: cleared when a miss is accepted, wraps after the last beat.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      beat <= {BEAT_W{1'b0}};
    end else if (accept_miss) begin
      beat <= {BEAT_W{1'b0}};
    end else if (beat_ack) begin
      beat <= last_beat ? {BEAT_W{1'b0}} : beat + {{(BEAT_W-1){1'b0}}, 1'b1};
    end else begin
      beat <= beat;
    end
  end

  // Latch line-aligned victim and refill addresses when leaving IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wb_base <= 32'd0;
      rf_base <= 32'd0;
    end else if (accept_miss) begin
      wb_base <= line_align(wb_addr);
      rf_base <= line_align(rf_addr);
    end else begin
      wb_base <= wb_base;
      rf_base <= rf_base;
    end
  end

  // Capture refill data word by word; words hold until the next refill.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        words[i] <= 32'd0;
      end
    end else if ((state == RF) && beat_ack && beat_in_ports) begin
      words[beat[1:0]] <= mem_rdata;
    end else begin
      for (int i = 0; i < 4; i++) begin
        words[i] <= words[i];
      end
    end
  end

  assign w0 = words[0];
  assign w1 = words[1];
  assign w2 = words[2];
  assign w3 = words[3];

`ifdef CACHE_STATS_EN
  logic hit_inc;
  assign hit_inc = (state == IDLE) && hit && !miss;

  cache_stat_ctr #(.CNT_W(CNT_W)) u_hit_ctr (
    .CLK (CLK),
    .RST (RST),
    .inc (hit_inc),
    .cnt (hit_cnt)
  );

  cache_stat_ctr #(.CNT_W(CNT_W)) u_miss_ctr (
    .CLK (CLK),
    .RST (RST),
    .inc (accept_miss),
    .cnt (miss_cnt)
  );
`else
  // hit only feeds the statistics; keep it visibly consumed when they are off.
  logic unused_hit;
  assign unused_hit = &{1'b0, hit};
  assign hit_cnt    = {CNT_W{1'b0}};
  assign miss_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: self-checking bench for cache_refill_ctrl.
// Each miss transaction is modelled as a timeline: cycle 0 is the IDLE cycle
// that accepts the miss, then nb beats of (delay+1) cycles each, then one
// update cycle. Expected bus values come from that schedule.
module tb_cache_refill_ctrl;

  localparam int          CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          hit, miss, evict_dirty;
  logic [31:0]   wb_addr, rf_addr, ow0, ow1, ow2, ow3;
  logic          stall, writeback, update;
  logic [31:0]   w0, w1, w2, w3;
  logic          mem_req, mem_we;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic          mem_ack;
  logic [CW-1:0] hit_cnt, miss_cnt;

  int tests = 0;
  int fails = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  cache_refill_ctrl #(.BLOCK_WORDS(4), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .hit(hit), .miss(miss), .evict_dirty(evict_dirty),
    .wb_addr(wb_addr), .rf_addr(rf_addr),
    .ow0(ow0), .ow1(ow1), .ow2(ow2), .ow3(ow3),
    .stall(stall), .writeback(writeback), .update(update),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] exp_cnt(input int v);
`ifdef CACHE_STATS_EN
    return (v > MAXC) ? 32'(MAXC) : 32'(v);
`else
    return 32'(v) & 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete miss; mem_ack is driven from the schedule, miss/hit/addresses
  // are scrambled after the accepting cycle to show they are ignored or latched.
  task automatic run_miss(input bit dirty, input int d, input logic [31:0] wa,
                          input logic [31:0] ra, input logic [31:0] o [4]);
    logic [31:0] rd [4];
    logic [31:0] wal, ral;
    int nb, active, total, b, rb, stalls;
    bit in_act, is_wb;
    for (int k = 0; k < 4; k++) rd[k] = $urandom;
    wal = wa & 32'hFFFF_FFF0;
    ral = ra & 32'hFFFF_FFF0;
    nb = dirty ? 8 : 4;
    active = nb * (d + 1);
    total = active + 1;
    stalls = 0;
    for (int c = 0; c <= total + 1; c++) begin
      tick();
      in_act = (c >= 1) && (c <= active);
      b = in_act ? (c - 1) / (d + 1) : 0;
      is_wb = dirty && (b < 4);
      rb = dirty ? b - 4 : b;
      ow0 = o[0]; ow1 = o[1]; ow2 = o[2]; ow3 = o[3];
      if (c == 0) begin
        miss = 1'b1; hit = 1'($urandom_range(0, 1)); evict_dirty = dirty;
        wb_addr = wa; rf_addr = ra;
      end else begin
        miss = (c <= total) ? 1'($urandom_range(0, 1)) : 1'b0;
        hit = (c <= total) ? 1'($urandom_range(0, 1)) : 1'b0;
        evict_dirty = 1'($urandom_range(0, 1));
        wb_addr = $urandom; rf_addr = $urandom;
      end
      if (d == 0) mem_ack = 1'b1;
      else if (in_act) mem_ack = ((c - 1) % (d + 1)) == d;
      else mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = (in_act && !is_wb) ? rd[rb] : $urandom;
      #1;
      if (stall === 1'b1) stalls++;
      check("stall", 32'(stall), 32'(c <= total));
      check("mem_req", 32'(mem_req), 32'(in_act));
      check("update", 32'(update), 32'(c == total));
      check("writeback", 32'(writeback), 32'(in_act && is_wb));
      if (in_act) begin
        check("mem_we", 32'(mem_we), 32'(is_wb));
        check("mem_addr", mem_addr, is_wb ? wal + 32'(4 * b) : ral + 32'(4 * rb));
        if (is_wb) check("mem_wdata", mem_wdata, o[b]);
      end
    end
    check("stall_len", 32'(stalls), 32'(nb * (d + 1) + 2));
    check("w0", w0, rd[0]);
    check("w1", w1, rd[1]);
    check("w2", w2, rd[2]);
    check("w3", w3, rd[3]);
    exp_misses++;
    check("miss_cnt", 32'(miss_cnt), exp_cnt(exp_misses));
  endtask

  task automatic run_hits(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      hit = 1'b1; miss = 1'b0;
      evict_dirty = 1'($urandom_range(0, 1));
      mem_ack = 1'($urandom_range(0, 1));
      #1;
      check("hit_stall", 32'(stall), 32'd0);
      check("hit_mem_req", 32'(mem_req), 32'd0);
      exp_hits++;
    end
    tick();
    hit = 1'b0;
    #1;
    check("hit_cnt", 32'(hit_cnt), exp_cnt(exp_hits));
  endtask

  initial begin
    logic [31:0] ov [4];
    RST = 1'b1; hit = 1'b0; miss = 1'b0; evict_dirty = 1'b0;
    wb_addr = 32'd0; rf_addr = 32'd0;
    ow0 = 32'd0; ow1 = 32'd0; ow2 = 32'd0; ow3 = 32'd0;
    mem_rdata = 32'd0; mem_ack = 1'b0;
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_update", 32'(update), 32'd0);
    check("rst_w0", w0, 32'd0);
    check("rst_w3", w3, 32'd0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Clean miss at 0x104C, zero-wait ack.
    for (int k = 0; k < 4; k++) ov[k] = $urandom;
    run_miss(1'b0, 0, 32'h0, 32'h0000_104C, ov);
    // Dirty miss, victim 0x2000 holding A..D.
    ov[0] = 32'hA; ov[1] = 32'hB; ov[2] = 32'hC; ov[3] = 32'hD;
    run_miss(1'b1, 0, 32'h0000_2000, 32'h0000_3008, ov);
    // Clean miss with three wait cycles per beat.
    run_miss(1'b0, 3, $urandom, $urandom, ov);
    // Randomised transactions.
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 4; k++) ov[k] = $urandom;
      run_miss(1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom, $urandom, ov);
    end
    // Hits, enough to saturate a 4-bit counter.
    run_hits(20);
    check("miss_cnt_final", 32'(miss_cnt), exp_cnt(exp_misses));

    // Reset during refill beat 2 of a clean miss.
    tick();
    miss = 1'b1; evict_dirty = 1'b0; rf_addr = $urandom; mem_ack = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      miss = 1'b0;
    end
    #1;
    check("pre_rst_mem_req", 32'(mem_req), 32'd1);
    RST = 1'b1;
    #1;
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_update", 32'(update), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_w0", w0, 32'd0);
    check("mid_rst_w1", w1, 32'd0);
    check("mid_rst_w2", w2, 32'd0);
    check("mid_rst_w3", w3, 32'd0);
    exp_hits = 0;
    exp_misses = 0;
    check("mid_rst_hit_cnt", 32'(hit_cnt), exp_cnt(exp_hits));
    check("mid_rst_miss_cnt", 32'(miss_cnt), exp_cnt(exp_misses));
    tick();
    RST = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      mem_ack = 1'($urandom_range(0, 1));
      #1;
      check("post_rst_update", 32'(update), 32'd0);
      check("post_rst_mem_req", 32'(mem_req), 32'd0);
    end

    // Controller still works after the aborted burst.
    for (int k = 0; k < 4; k++) ov[k] = $urandom;
    run_miss(1'b1, 1, $urandom, $urandom, ov);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
